// File: rtl/clock_display_scan.sv
// clock_display_scan
//   Drives a 6-digit common-anode multiplexed seven-segment display (HH MM SS) from the
//   clock core's binary time bus. The time is snapshotted once per scan frame, each field
//   is split into BCD by compare/subtract, and one digit is enabled per refresh period.
//   fmt12 selects 12-hour presentation, with PM shown on the seconds-ones decimal point.
//
// Optional feature macro: CLOCK_DISPLAY_COLON_BLINK_EN
//   Defined   : dp at the minutes-ones and hours-ones digits blinks with the seconds.
//   Undefined : those dp outputs stay dark and no blink logic is built.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   seconds  in   [5:0] binary seconds, 0-59 valid
//   minutes  in   [5:0] binary minutes, 0-59 valid
//   hours    in   [4:0] binary hours, 0-23 valid
//   fmt12    in   1 = 12-hour display, 0 = 24-hour display
//   an       out  [5:0] digit enables, active-low
//   seg      out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp       out  decimal point, active-low
module clock_display_scan #(
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic       fmt12,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          tick;

    logic [5:0] sec_q, min_q;
    logic [4:0] hr_q;
    logic       fmt_q;

    logic [5:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;

    // Repeated subtraction of ten; inputs never exceed 63 so six passes suffice.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d, input logic dash);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            default: c = SEG_DASH;
        endcase
        return dash ? SEG_DASH : c;
    endfunction

    // Refresh counter and digit index
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Snapshot taken on the edge where the index wraps 5 -> 0, so a frame is coherent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_q <= 6'd0;
            min_q <= 6'd0;
            hr_q  <= 5'd0;
            fmt_q <= 1'b0;
        end else if (tick && idx_q == 3'd5) begin
            sec_q <= seconds;
            min_q <= minutes;
            hr_q  <= hours;
            fmt_q <= fmt12;
        end
    end

    // Digit decode from current index and snapshot
    logic       sec_bad, min_bad, hr_bad, pm, colon_dp, bad;
    logic [4:0] hr_disp;
    logic [7:0] sec_bcd, min_bcd, hr_bcd;
    logic [3:0] digit;

    always_comb begin
        sec_bad = (sec_q > 6'd59);
        min_bad = (min_q > 6'd59);
        hr_bad  = (hr_q > 5'd23);
        pm      = !hr_bad && (hr_q >= 5'd12);

        hr_disp = hr_q;
        if (fmt_q && !hr_bad) begin
            if (hr_q == 5'd0) begin
                hr_disp = 5'd12;
            end else if (hr_q > 5'd12) begin
                hr_disp = hr_q - 5'd12;
            end
        end

        sec_bcd = to_bcd(sec_q);
        min_bcd = to_bcd(min_q);
        hr_bcd  = to_bcd({1'b0, hr_disp});

`ifdef CLOCK_DISPLAY_COLON_BLINK_EN
        colon_dp = sec_bad || sec_q[0];
`else
        colon_dp = 1'b1;
`endif

        an_d  = 6'b111111;
        digit = 4'd0;
        bad   = 1'b1;
        dp_d  = 1'b1;
        case (idx_q)
            3'd0: begin digit = sec_bcd[3:0]; bad = sec_bad; dp_d = !(fmt_q && pm); end
            3'd1: begin digit = sec_bcd[7:4]; bad = sec_bad; end
            3'd2: begin digit = min_bcd[3:0]; bad = min_bad; dp_d = colon_dp; end
            3'd3: begin digit = min_bcd[7:4]; bad = min_bad; end
            3'd4: begin digit = hr_bcd[3:0];  bad = hr_bad;  dp_d = colon_dp; end
            3'd5: begin digit = hr_bcd[7:4];  bad = hr_bad;  end
            default: ;
        endcase
        if (idx_q <= 3'd5) begin
            an_d = ~(6'b000001 << idx_q);
        end
        seg_d = (idx_q <= 3'd5) ? seg_code(digit, bad) : 7'b1111111;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 6'b111111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan
//   Table-driven check of clock_display_scan with REFRESH_DIV=4: each record holds a time
//   input and the six segment codes plus dp values expected over the following frame.
//   Hand-written sequences cover reset, mid-frame input changes and mid-scan reset.
//   Follows CLOCK_DISPLAY_COLON_BLINK_EN for the colon dp expectation.
module tb_clock_display_scan;

    localparam int unsigned DIV = 4;
    localparam int unsigned FRAME = 6 * DIV;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000, SD = 7'b0111111;

    typedef struct {
        logic [5:0]      s;
        logic [5:0]      m;
        logic [4:0]      h;
        logic            f;
        logic [5:0][6:0] sg;   // sg[i] = expected code at digit index i
        logic            dp0;
        logic            col;  // colon dp when blink is built in
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] seconds = 6'd56, minutes = 6'd34;
    logic [4:0] hours = 5'd12;
    logic       fmt12 = 1'b0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad = 0;
    int n = 0;

    vec_t vecs[8];
    vec_t vzero, v1, v1b;

    always #5 clk = ~clk;

    clock_display_scan #(.REFRESH_DIV(DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .seconds(seconds),
        .minutes(minutes),
        .hours  (hours),
        .fmt12  (fmt12),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    function automatic vec_t mk(input int s, input int m, input int h, input logic f,
                                input logic [6:0] d5, input logic [6:0] d4,
                                input logic [6:0] d3, input logic [6:0] d2,
                                input logic [6:0] d1, input logic [6:0] d0,
                                input logic dp0, input logic col);
        vec_t v;
        v.s = 6'(s);
        v.m = 6'(m);
        v.h = 5'(h);
        v.f = f;
        v.sg = {d5, d4, d3, d2, d1, d0};
        v.dp0 = dp0;
        v.col = col;
        return v;
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        seconds = v.s;
        minutes = v.m;
        hours = v.h;
        fmt12 = v.f;
    endtask

    // Advance to the next frame boundary (the snapshot edge), at least one edge on.
    task automatic sync();
        tick();
        while (n % FRAME != 0) tick();
    endtask

    // One cycle at frame position k (0..23): digit index k/DIV.
    task automatic check_cycle(input vec_t v, input int k, input string tag);
        int         idx;
        logic [5:0] ean;
        logic       edp;
        tick();
        idx = k / DIV;
        ean = ~(6'b000001 << idx);
        edp = 1'b1;
        if (idx == 0) edp = v.dp0;
`ifdef CLOCK_DISPLAY_COLON_BLINK_EN
        if (idx == 2 || idx == 4) edp = v.col;
`endif
        check($sformatf("%s an k=%0d", tag, k), {1'b0, an}, {1'b0, ean});
        check($sformatf("%s seg k=%0d", tag, k), seg, v.sg[idx]);
        check($sformatf("%s dp k=%0d", tag, k), {6'd0, dp}, {6'd0, edp});
    endtask

    task automatic check_frame(input vec_t v, input string tag);
        for (int k = 0; k < FRAME; k++) check_cycle(v, k, tag);
    endtask

    initial begin
        vzero = mk(0, 0, 0, 0, S0, S0, S0, S0, S0, S0, 1'b1, 1'b0);
        v1    = mk(56, 34, 12, 0, S1, S2, S3, S4, S5, S6, 1'b1, 1'b0);
        v1b   = mk(57, 35, 12, 0, S1, S2, S3, S5, S5, S7, 1'b1, 1'b1);

        vecs[0] = v1;
        vecs[1] = mk(7, 8, 0, 1, S1, S2, S0, S8, S0, S7, 1'b1, 1'b1);   // 0h -> 12, AM
        vecs[2] = mk(10, 59, 13, 1, S0, S1, S5, S9, S1, S0, 1'b0, 1'b0); // 13h -> 01 PM
        vecs[3] = mk(11, 0, 12, 1, S1, S2, S0, S0, S1, S1, 1'b0, 1'b1);  // noon, PM
        vecs[4] = mk(61, 5, 7, 0, S0, S7, S0, S5, SD, SD, 1'b1, 1'b1);   // bad seconds
        vecs[5] = mk(59, 9, 23, 0, S2, S3, S0, S9, S5, S9, 1'b1, 1'b1);
        vecs[6] = mk(0, 60, 24, 1, SD, SD, SD, SD, S0, S0, 1'b1, 1'b0);  // bad min/hours, no PM
        vecs[7] = mk(2, 45, 23, 1, S1, S1, S4, S5, S0, S2, 1'b0, 1'b0);  // 23h -> 11 PM

        // Held in reset: all outputs blank regardless of inputs
        repeat (3) @(negedge clk);
        check("reset an", {1'b0, an}, 7'b0111111);
        check("reset seg", seg, 7'b1111111);
        check("reset dp", {6'd0, dp}, 7'd1);

        reset = 1'b1;
        n = 0;
        check_frame(vzero, "first");

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i]);
            sync();
            check_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Inputs changed mid-frame only show up in the next frame
        apply(v1);
        sync();
        for (int k = 0; k < FRAME; k++) begin
            check_cycle(v1, k, "coh_a");
            if (k == 2 * DIV) begin
                seconds = 6'd57;
                minutes = 6'd35;
            end
        end
        check_frame(v1b, "coh_b");

        // Reset mid-scan at idx3 blanks immediately, then scan restarts from idx0
        for (int k = 0; k <= 3 * DIV; k++) check_cycle(v1b, k, "pre_rst");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst an", {1'b0, an}, 7'b0111111);
        check("midrst seg", seg, 7'b1111111);
        check("midrst dp", {6'd0, dp}, 7'd1);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        check_frame(vzero, "after_rst");
        check_frame(v1b, "after_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
